// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Package     : calc_pkg
// Description : Glyph codes, active-low seven-segment patterns and display
//               state type shared by the calculator result display.
// Revision    : 1.0 - initial release
// ============================================================================
package calc_pkg;

  // Glyph codes; 0..9 are the decimal digits themselves
  localparam logic [3:0] GLYPH_MINUS = 4'd10;
  localparam logic [3:0] GLYPH_E     = 4'd11;
  localparam logic [3:0] GLYPH_R     = 4'd12;
  localparam logic [3:0] GLYPH_BLANK = 4'd15;

  // Segment patterns, bit order {g,f,e,d,c,b,a}, a 0 lights the segment
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_MINUS = 7'h3F;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_R     = 7'h2F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SHOW = 2'd1,
    ERR  = 2'd2
  } disp_state_e;

endpackage
`default_nettype wire

// File: rtl/seg7_encode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_encode
// Description : Combinational glyph code to active-low segment pattern.
//               Unassigned codes render blank.
// Revision    : 1.0 - initial release
// ============================================================================
module seg7_encode
  import calc_pkg::*;
(
  input  logic [3:0] glyph_i,
  output logic [6:0] seg_n_o
);

  // Lookup of the segment pattern for each glyph code
  always_comb begin
    seg_n_o = SEG_BLANK;
    case (glyph_i)
      4'd0:        seg_n_o = SEG_0;
      4'd1:        seg_n_o = SEG_1;
      4'd2:        seg_n_o = SEG_2;
      4'd3:        seg_n_o = SEG_3;
      4'd4:        seg_n_o = SEG_4;
      4'd5:        seg_n_o = SEG_5;
      4'd6:        seg_n_o = SEG_6;
      4'd7:        seg_n_o = SEG_7;
      4'd8:        seg_n_o = SEG_8;
      4'd9:        seg_n_o = SEG_9;
      GLYPH_MINUS: seg_n_o = SEG_MINUS;
      GLYPH_E:     seg_n_o = SEG_E;
      GLYPH_R:     seg_n_o = SEG_R;
      default:     seg_n_o = SEG_BLANK;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/calc_result_display.sv
`default_nettype none
// ============================================================================
// Module      : calc_result_display
// Description : Accepts an ALU result over valid/ready, stores it and scans it
//               onto a 4-digit common-anode seven-segment display. After each
//               accept, ready is held low for one full scan frame.
//               Option macro CALC_DISP_LZB_EN: blank the tens digit of a
//               numeric result below 10.
// Revision    : 1.0 - initial release
// ============================================================================
module calc_result_display
  import calc_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       res_valid,
  output logic       res_ready,
  input  logic [3:0] res_value,
  input  logic       res_sign,
  input  logic       res_zero,
  input  logic       res_dz,
  input  logic       clr,
  output logic [6:0] seg_n,
  output logic [3:0] an_n
);

  localparam logic [15:0] SCAN_LAST  = 16'(SCAN_DIV - 1);
  localparam logic [17:0] FRAME_LAST = 18'((4 * SCAN_DIV) - 1);

  disp_state_e state_q, state_d;
  logic [3:0]  value_q, value_d;
  logic        sign_q,  sign_d;
  logic        zero_q,  zero_d;
  logic [15:0] scan_q,  scan_d;
  logic [1:0]  digit_q, digit_d;
  logic [17:0] hold_q,  hold_d;
  logic        ready_q, ready_d;
  logic [6:0]  seg_q,   seg_d;
  logic [3:0]  an_q,    an_d;
  logic [3:0]  glyph_d;
  logic [3:0]  tens_d;
  logic [3:0]  units_d;
  logic        accept;

  assign accept    = res_valid && ready_q;
  assign res_ready = ready_q;
  assign seg_n     = seg_q;
  assign an_n      = an_q;

  // Next state: clear beats accept, accept starts the one-frame holdoff
  always_comb begin
    state_d = state_q;
    value_d = value_q;
    sign_d  = sign_q;
    zero_d  = zero_q;
    ready_d = ready_q;
    hold_d  = hold_q;
    if (clr) begin
      state_d = IDLE;
      value_d = 4'd0;
      sign_d  = 1'b0;
      zero_d  = 1'b0;
      ready_d = 1'b1;
      hold_d  = 18'd0;
    end else if (accept) begin
      state_d = res_dz ? ERR : SHOW;
      value_d = res_value;
      sign_d  = res_sign;
      zero_d  = res_zero;
      ready_d = 1'b0;
      hold_d  = 18'd0;
    end else if (!ready_q) begin
      if (hold_q == FRAME_LAST) begin
        ready_d = 1'b1;
      end else begin
        hold_d = hold_q + 18'd1;
      end
    end
  end

  // Free-running digit scan, independent of accepts
  always_comb begin
    scan_d  = scan_q + 16'd1;
    digit_d = digit_q;
    if (scan_q == SCAN_LAST) begin
      scan_d  = 16'd0;
      digit_d = digit_q + 2'd1;
    end
  end

  // Glyph and anode select for the digit that will be lit after this edge
  always_comb begin
    glyph_d = GLYPH_BLANK;
    an_d    = 4'hF;
    tens_d  = (value_d >= 4'd10) ? 4'd1 : 4'd0;
    units_d = (value_d >= 4'd10) ? (value_d - 4'd10) : value_d;
    if (state_d != IDLE) begin
      an_d = ~(4'b0001 << digit_d);
    end
    case (state_d)
      SHOW: begin
        case (digit_d)
          2'd3: glyph_d = (sign_d && !zero_d) ? GLYPH_MINUS : GLYPH_BLANK;
          2'd2: glyph_d = GLYPH_BLANK;
`ifdef CALC_DISP_LZB_EN
          2'd1: glyph_d = (value_d < 4'd10) ? GLYPH_BLANK : tens_d;
`else
          2'd1: glyph_d = tens_d;
`endif
          default: glyph_d = units_d;
        endcase
      end
      ERR: begin
        case (digit_d)
          2'd3:    glyph_d = GLYPH_E;
          2'd2:    glyph_d = GLYPH_R;
          2'd1:    glyph_d = GLYPH_R;
          default: glyph_d = GLYPH_BLANK;
        endcase
      end
      default: glyph_d = GLYPH_BLANK;
    endcase
  end

  seg7_encode u_seg7_encode (
    .glyph_i (glyph_d),
    .seg_n_o (seg_d)
  );

  // State, result, counters and display pins all update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      value_q <= 4'd0;
      sign_q  <= 1'b0;
      zero_q  <= 1'b0;
      scan_q  <= 16'd0;
      digit_q <= 2'd0;
      hold_q  <= 18'd0;
      ready_q <= 1'b1;
      seg_q   <= SEG_BLANK;
      an_q    <= 4'hF;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      sign_q  <= sign_d;
      zero_q  <= zero_d;
      scan_q  <= scan_d;
      digit_q <= digit_d;
      hold_q  <= hold_d;
      ready_q <= ready_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

endmodule
`default_nettype wire

// File: doc/calc_result_display.md
# calc_result_display

Consumer end of the calculator datapath: accepts a result and flags from the ALU through a valid/ready handshake and registers them. Renders the stored result on a 4-digit, common-anode, time-multiplexed seven-segment display. Shows a sign, two decimal digits, or an error glyph. Sits between the ALU output and the board display pins.

## Interface
- SCAN_DIV, 1000: clock cycles each digit is lit; legal range 1..65535.
- clk  in  1  system clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- res_valid  in  1  producer presents a result this cycle.
- res_ready  out  1  block can accept a result this cycle.
- res_value  in  4  unsigned result magnitude, 0..15.
- res_sign  in  1  result negative.
- res_zero  in  1  result is zero.
- res_dz  in  1  divide-by-zero; overrides value and sign.
- clr  in  1  synchronous clear to blank display.
- seg_n  out  7  segments {g,f,e,d,c,b,a}, active-low.
- an_n  out  4  digit enables; bit 3 is the leftmost digit; active-low, at most one low.

## Operation
- States:
  - IDLE: display blank, all an_n high.
  - SHOW: numeric result on display.
  - ERR: error glyph on display.
- Reset and clr both go to IDLE and clear the stored result.
- Accept occurs when res_valid && res_ready.
  - res_dz=1: capture, go to ERR.
  - res_dz=0: capture, go to SHOW.
  - An accept in any state replaces the stored result.
- res_valid while res_ready=0 is ignored; the producer holds its data.
- res_ready drops the cycle after an accept. It stays low for one full frame (4*SCAN_DIV cycles), so every result is shown at least once. It then rises again. It is 1 in IDLE.
- SHOW glyphs, from digit 3 down to digit 0:
  - Digit 3: sign. '-' if res_sign=1 and res_zero=0, else blank. res_zero=1 suppresses the sign.
  - Digit 2: blank.
  - Digit 1: tens digit, res_value/10, so 0 or 1.
  - Digit 0: units digit, res_value%10.
  - Units are always shown; a value of 0 displays "0".
- ERR glyphs, from digit 3 down to digit 0: 'E', 'r', 'r', blank.
- A blank digit still gets its scan slot, with seg_n=7'h7F and that digit's an_n bit low.
- Glyph encoding (4-bit): 0..9 are digits, 10 = minus, 11 = E, 12 = r, 15 = blank.

## Timing
- Reset values:
  - res_ready=1, seg_n=7'h7F, an_n=4'hF.
  - Scan counter 0, digit index 0, state IDLE.
- Scan counter counts 0..SCAN_DIV-1. At its terminal count the digit index advances 0→1→2→3→0, wrapping.
- seg_n and an_n are both registered and change on the same edge. There is no ghosting cycle.
- Accept latency: the new glyph appears on the next edge at which the current digit is refreshed. The scan position is not reset by an accept.
- Holdoff frame counter starts on the accept edge. res_ready is high again exactly 4*SCAN_DIV cycles after it dropped.
- clr has priority over a simultaneous accept: the result is discarded, state goes to IDLE, and res_ready=1 on the next cycle.
- Reset asserted mid-frame blanks the outputs immediately (asynchronously).
- SCAN_DIV=1: the digit advances every cycle.

## Configuration
- CALC_DISP_LZB_EN defined: leading-zero blanking. The tens digit is blank when res_value<10, in SHOW only.
- Undefined: the tens digit always shows, so 7 displays as " 07".
- ERR glyphs are unaffected by the macro.

## Structure
- calc_pkg holds:
  - glyph code localparams: GLYPH_MINUS, GLYPH_E, GLYPH_R, GLYPH_BLANK;
  - the 7-bit segment pattern constants;
  - the display state enum (IDLE/SHOW/ERR).
- Sub-module seg7_encode: combinational 4-bit glyph to 7-bit active-low segment pattern, instantiated once on the muxed glyph.
- Top level holds the FSM, scan counter, holdoff counter, and result registers.

## Test plan
All scenarios use SCAN_DIV=4.
- Reset release: an_n=4'hF, seg_n=7'h7F, res_ready=1 for 20 cycles.
- Accept value=13, sign=1 (`CALC_DISP_LZB_EN` undefined): one frame shows digit 3 '-', digit 2 blank, digit 1 '1', digit 0 '3'. res_ready low for exactly 16 cycles.
- Accept value=0, sign=1, zero=1: digit 3 blank, digit 0 '0' (7'h40). Under `CALC_DISP_LZB_EN`, value=5 shows digit 1 blank.
- Accept dz=1 with value=9: digits show 'E','r','r',blank. A second res_valid during holdoff is ignored and the display is unchanged.
- clr asserted together with res_valid while in SHOW: next cycle state is IDLE, all an_n high, res_ready=1.
- rst_n pulsed low mid-frame in ERR: outputs blank within the same cycle. After release the display stays blank until the next accept.
